// File: rtl/router_mem_arbiter.sv
// Round-robin arbiter sharing the single-port packet buffer RAM between NUM_REQ requesters.
// A winner is granted for one cycle and then runs a BURST_LEN-beat read or write burst at
// consecutive, wrapping addresses. A drain cycle follows, then a done pulse, and priority
// rotates to the next requester.
// Optional build macro: ARB_FIXED_PRIORITY_EN pins the priority pointer at 0, so the
// lowest-index active requester always wins.
module router_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned BURST_LEN  = 19
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_rd,
  input  logic [NUM_REQ-1:0]            i_req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_gnt_rd,
  output logic [NUM_REQ-1:0]            o_gnt_wr,
  output logic [NUM_REQ-1:0]            o_beat_ack,
  output logic [NUM_REQ-1:0]            o_rdata_valid,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic [NUM_REQ-1:0]            o_done,
  output logic                          o_mem_en,
  output logic                          o_mem_we,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

  typedef enum logic [2:0] {StIdle, StGrant, StBurst, StDrain, StDone} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [PtrW-1:0]        r_owner;
  logic [PtrW-1:0]        r_ptr;
  logic                   r_op_wr;
  logic [CntW-1:0]        r_beat;
  logic                   r_mem_en;
  logic                   r_mem_we;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic                   r_rd_pipe;
  logic                   r_rvalid;
  logic [DATA_WIDTH-1:0]  r_rdata;

  logic [NUM_REQ-1:0]     w_active;
  logic                   w_any;
  logic [PtrW-1:0]        w_winner;
  int unsigned            w_idx;
  logic [ADDR_WIDTH-1:0]  w_win_addr;
  logic                   w_win_wr;
  logic [NUM_REQ-1:0]     w_owner_oh;
  logic [DATA_WIDTH-1:0]  w_owner_wdata;

  assign w_active = i_req_rd | i_req_wr;

  // Pick the first active requester at or after the priority pointer, wrapping.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_any && (j == w_idx) && w_active[j]) begin
          w_any    = 1'b1;
          w_winner = PtrW'(j);
        end
      end
    end
  end

  // Select the winner's base address and op, and the current owner's one-hot and write data.
  always_comb begin
    w_win_addr    = '0;
    w_win_wr      = 1'b0;
    w_owner_oh    = '0;
    w_owner_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_winner == PtrW'(i)) begin
        w_win_addr = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_wr   = i_req_wr[i];  // write beats a simultaneous read from the same requester
      end
      if (r_owner == PtrW'(i)) begin
        w_owner_oh[i] = 1'b1;
        w_owner_wdata = i_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_any) w_state_nxt = StGrant;
      StGrant: w_state_nxt = StBurst;
      StBurst: if (r_beat == LastBeat) w_state_nxt = StDrain;
      StDrain: w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Owner/op latch, beat counter and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= '0;
      r_op_wr <= 1'b0;
      r_beat  <= '0;
      r_ptr   <= '0;
    end else begin
      if (r_state == StIdle && w_any) begin
        r_owner <= w_winner;
        r_op_wr <= w_win_wr;
      end
      if (r_state == StBurst && r_beat != LastBeat) begin
        r_beat <= r_beat + 1'b1;
      end else begin
        r_beat <= '0;
      end
      if (r_state == StDone) begin
`ifdef ARB_FIXED_PRIORITY_EN
        r_ptr <= '0;
`else
        r_ptr <= (r_owner == PtrW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
`endif
      end
    end
  end

  // Registered RAM controls; the address is loaded with the base on arbitration and
  // advances once per beat, wrapping naturally at the address width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_en <= (w_state_nxt == StBurst);
      r_mem_we <= (w_state_nxt == StBurst) && r_op_wr;
      if (r_state == StIdle && w_any) begin
        r_mem_addr <= w_win_addr;
      end else if (r_state == StBurst) begin
        r_mem_addr <= r_mem_addr + 1'b1;
      end
    end
  end

  // Read return: RAM data arrives one cycle after a read beat and is registered once more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pipe <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_pipe <= r_mem_en && !r_mem_we;
      r_rvalid  <= r_rd_pipe;
      if (r_rd_pipe) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_gnt_rd      = (r_state == StGrant && !r_op_wr) ? w_owner_oh : '0;
  assign o_gnt_wr      = (r_state == StGrant &&  r_op_wr) ? w_owner_oh : '0;
  assign o_beat_ack    = (r_state == StBurst) ? w_owner_oh : '0;
  assign o_done        = (r_state == StDone)  ? w_owner_oh : '0;
  assign o_rdata_valid = r_rvalid ? w_owner_oh : '0;
  assign o_rdata       = r_rdata;
  assign o_mem_en      = r_mem_en;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = w_owner_wdata;

endmodule

// File: tb/tb_router_mem_arbiter.sv
// Directed bench for router_mem_arbiter: single read, single write, contention, address wrap,
// same-requester read+write and reset mid-burst, against a behavioural RAM with 1-cycle reads.
// Honours ARB_FIXED_PRIORITY_EN for the contention ordering.
module tb_router_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 2;
  localparam int unsigned BL = 19;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_rd, req_wr;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     gnt_rd, gnt_wr, beat_ack, rdata_valid, done;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;

  router_mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .BURST_LEN  (BL)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_rd      (req_rd),
    .i_req_wr      (req_wr),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_gnt_rd      (gnt_rd),
    .o_gnt_wr      (gnt_wr),
    .o_beat_ack    (beat_ack),
    .o_rdata_valid (rdata_valid),
    .o_rdata       (rdata),
    .o_done        (done),
    .o_mem_en      (mem_en),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] ram [1024];
  logic [DW-1:0] rd_pending;
  logic [DW-1:0] wbase [NR];
  int            wcnt [NR];
  logic [NR-1:0] prev_ack;

  int cyc = 0;
  int n_gnt_rd [NR];
  int n_gnt_wr [NR];
  int n_beat [NR];
  int n_rv [NR];
  int n_done_total, n_we, overlap_err;
  int t_first_beat, t_last_beat, t_first_rv, t_last_rv, t_done;
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_rdata [$];
  int q_gnt_who [$];
  int q_gnt_wr [$];
  int q_gnt_t [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  task automatic clear_log();
    for (int i = 0; i < int'(NR); i++) begin
      n_gnt_rd[i] = 0; n_gnt_wr[i] = 0; n_beat[i] = 0; n_rv[i] = 0; wcnt[i] = 0;
    end
    n_done_total = 0; n_we = 0; overlap_err = 0; prev_ack = '0;
    t_first_beat = -1; t_last_beat = -1; t_first_rv = -1; t_last_rv = -1; t_done = -1;
    q_addr.delete(); q_rdata.delete();
    q_gnt_who.delete(); q_gnt_wr.delete(); q_gnt_t.delete();
  endtask

  // One clock: writer data update, then sample outputs and serve the RAM model mid-cycle.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < int'(NR); i++) begin
      if (prev_ack[i]) wcnt[i]++;
      req_wdata[i*DW +: DW] = wbase[i] + 64'(wcnt[i]);
    end
    #1;
    prev_ack = beat_ack;
    if ($countones(gnt_rd | gnt_wr) > 1 || $countones(beat_ack) > 1 || $countones(done) > 1)
      overlap_err++;
    for (int i = 0; i < int'(NR); i++) begin
      if (gnt_rd[i] || gnt_wr[i]) begin
        q_gnt_who.push_back(i); q_gnt_wr.push_back(int'(gnt_wr[i])); q_gnt_t.push_back(cyc);
      end
      if (gnt_rd[i]) n_gnt_rd[i]++;
      if (gnt_wr[i]) n_gnt_wr[i]++;
      if (beat_ack[i]) n_beat[i]++;
      if (rdata_valid[i]) n_rv[i]++;
    end
    if (|done) begin
      n_done_total++;
      t_done = cyc;
    end
    if (|rdata_valid) begin
      q_rdata.push_back(rdata);
      if (t_first_rv < 0) t_first_rv = cyc;
      t_last_rv = cyc;
    end
    mem_rdata = rd_pending;
    if (mem_en) begin
      q_addr.push_back(mem_addr);
      if (t_first_beat < 0) t_first_beat = cyc;
      t_last_beat = cyc;
      if (mem_we) begin
        n_we++;
        ram[mem_addr] = mem_wdata;
      end else begin
        rd_pending = ram[mem_addr];
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (n_done_total < target && n < budget) begin
      step();
      n++;
    end
    check("done_reached", 64'(n_done_total), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    for (int a = 0; a < 1024; a++) ram[a] = pat(a);
    rd_pending = '0; mem_rdata = '0;
    wbase[0] = '0; wbase[1] = '0;
    rst_n = 1'b0; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    clear_log();
    step(); step();
    check("rst_gnt", 64'({gnt_rd, gnt_wr}), 64'(0));
    check("rst_ack_rv_done", 64'({beat_ack, rdata_valid, done}), 64'(0));
    check("rst_mem_ctl", 64'({mem_en, mem_we, mem_addr}), 64'(0));
    check("rst_rdata", rdata, 64'(0));
    rst_n = 1'b1;
    step();

    // Single read by requester 0 from 0x010.
    clear_log();
    req_addr[0 +: AW] = 10'h010; req_rd[0] = 1'b1; t0 = cyc;
    wait_done(1, 40);
    req_rd[0] = 1'b0;
    check("rd_gnt_cnt", 64'(n_gnt_rd[0]), 64'(1));
    check("rd_gnt_t", 64'(q_gnt_t.size() > 0 ? q_gnt_t[0] : -1), 64'(t0 + 1));
    check("rd_no_wgnt", 64'(n_gnt_wr[0] + n_gnt_wr[1]), 64'(0));
    check("rd_beats", 64'(q_addr.size()), 64'(BL));
    check("rd_beat_t0", 64'(t_first_beat), 64'(t0 + 2));
    check("rd_beat_tn", 64'(t_last_beat), 64'(t0 + 20));
    check("rd_ack_cnt", 64'(n_beat[0]), 64'(BL));
    check("rd_rv_cnt", 64'(n_rv[0]), 64'(BL));
    check("rd_rv_t0", 64'(t_first_rv), 64'(t0 + 4));
    check("rd_rv_tn", 64'(t_last_rv), 64'(t0 + 22));
    check("rd_done_t", 64'(t_done), 64'(t0 + 22));
    check("rd_no_we", 64'(n_we), 64'(0));
    for (int k = 0; k < int'(BL); k++) begin
      check("rd_addr", 64'(k < q_addr.size() ? q_addr[k] : 10'h3FF), 64'(10'h010 + k));
      check("rd_data", k < q_rdata.size() ? q_rdata[k] : 64'hX, pat(32'h010 + k));
    end
    step();

    // Single write by requester 1 to 0x100, data 0xA0 upward.
    clear_log();
    wbase[1] = 64'hA0;
    req_addr[AW +: AW] = 10'h100; req_wr[1] = 1'b1; t0 = cyc;
    wait_done(1, 40);
    req_wr[1] = 1'b0;
    check("wr_gnt_cnt", 64'(n_gnt_wr[1]), 64'(1));
    check("wr_no_rgnt", 64'(n_gnt_rd[0] + n_gnt_rd[1]), 64'(0));
    check("wr_we_cycles", 64'(n_we), 64'(BL));
    check("wr_ack_cnt", 64'(n_beat[1]), 64'(BL));
    check("wr_done_t", 64'(t_done), 64'(t0 + 22));
    for (int k = 0; k < int'(BL); k++) check("wr_ram", ram[10'h100 + k], 64'(8'hA0 + k));
    check("wr_ram_after", ram[10'h113], pat(32'h113));
    step();

    // Contention: requester 0 reads, requester 1 writes, both held across three bursts.
    clear_log();
    wbase[1] = 64'h300;
    req_addr[0 +: AW] = 10'h020; req_addr[AW +: AW] = 10'h200;
    req_rd[0] = 1'b1; req_wr[1] = 1'b1;
    wait_done(3, 120);
    req_rd[0] = 1'b0; req_wr[1] = 1'b0;
    step(); step();
    check("ct_gnts", 64'(q_gnt_who.size()), 64'(3));
    check("ct_overlap", 64'(overlap_err), 64'(0));
`ifdef ARB_FIXED_PRIORITY_EN
    check("ct_who1", 64'(q_gnt_who.size() > 1 ? q_gnt_who[1] : -1), 64'(0));
    check("ct_op1", 64'(q_gnt_wr.size() > 1 ? q_gnt_wr[1] : -1), 64'(0));
`else
    check("ct_who1", 64'(q_gnt_who.size() > 1 ? q_gnt_who[1] : -1), 64'(1));
    check("ct_op1", 64'(q_gnt_wr.size() > 1 ? q_gnt_wr[1] : -1), 64'(1));
`endif
    check("ct_who0", 64'(q_gnt_who.size() > 0 ? q_gnt_who[0] : -1), 64'(0));
    check("ct_who2", 64'(q_gnt_who.size() > 2 ? q_gnt_who[2] : -1), 64'(0));
    check("ct_spacing",
          64'(q_gnt_t.size() > 1 ? q_gnt_t[1] - q_gnt_t[0] : -1), 64'(BL + 4));

    // Address wrap from 0x3F8.
    clear_log();
    req_addr[0 +: AW] = 10'h3F8; req_rd[0] = 1'b1;
    wait_done(1, 40);
    req_rd[0] = 1'b0;
    check("wrap_beats", 64'(q_addr.size()), 64'(BL));
    for (int k = 0; k < int'(BL); k++) begin
      check("wrap_addr", 64'(k < q_addr.size() ? q_addr[k] : 10'h1FF),
            64'((32'h3F8 + k) % 1024));
      check("wrap_data", k < q_rdata.size() ? q_rdata[k] : 64'hX, pat((32'h3F8 + k) % 1024));
    end
    step();

    // Same-requester read+write: the write goes first, the read follows and sees its data.
    clear_log();
    wbase[0] = 64'h500;
    req_addr[0 +: AW] = 10'h040; req_rd[0] = 1'b1; req_wr[0] = 1'b1;
    wait_done(1, 40);
    req_wr[0] = 1'b0;
    wait_done(2, 40);
    req_rd[0] = 1'b0;
    check("rw_gnts", 64'(q_gnt_who.size()), 64'(2));
    check("rw_first_wr", 64'(q_gnt_wr.size() > 0 ? q_gnt_wr[0] : -1), 64'(1));
    check("rw_then_rd", 64'(q_gnt_wr.size() > 1 ? q_gnt_wr[1] : -1), 64'(0));
    check("rw_we", 64'(n_we), 64'(BL));
    check("rw_rv_cnt", 64'(n_rv[0]), 64'(BL));
    for (int k = 0; k < int'(BL); k++)
      check("rw_data", k < q_rdata.size() ? q_rdata[k] : 64'hX, 64'(12'h500 + k));
    step();

    // Reset during a read burst by requester 1, then a fresh burst.
    clear_log();
    req_addr[AW +: AW] = 10'h080; req_rd[1] = 1'b1;
    n = 0;
    while (q_addr.size() < 5 && n < 40) begin
      step();
      n++;
    end
    check("mid_beats", 64'(q_addr.size()), 64'(5));
    rst_n = 1'b0;
    step();
    check("mid_rst_ctl", 64'({mem_en, mem_we, mem_addr}), 64'(0));
    check("mid_rst_outs", 64'({gnt_rd, gnt_wr, beat_ack, rdata_valid, done}), 64'(0));
    check("mid_rst_rdata", rdata, 64'(0));
    rst_n = 1'b1;
    clear_log();
    t0 = cyc;
    wait_done(1, 40);
    req_rd[1] = 1'b0;
    check("post_gnt_t", 64'(q_gnt_t.size() > 0 ? q_gnt_t[0] : -1), 64'(t0 + 1));
    check("post_beats", 64'(n_beat[1]), 64'(BL));
    check("post_first", 64'(q_addr.size() > 0 ? q_addr[0] : 10'h3FF), 64'(10'h080));
    check("post_last", 64'(q_addr.size() > 18 ? q_addr[18] : 10'h3FF), 64'(10'h092));
    check("post_data", q_rdata.size() > 0 ? q_rdata[0] : 64'hX, pat(32'h080));
    check("post_done_t", 64'(t_done), 64'(t0 + 22));
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
